ocp_slave_mem: RTL and testbench



---
 rtl/ocp_slave_mem.sv | 150 +++++++++++++++
 tb/tb_ocp_slave_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_slave_mem.sv
// OCP 2.x basic-signal slave with a word-addressed memory and programmable response latency.
// Define OCP_WRRESP_EN to give writes a DVA/ERR response; otherwise writes are posted.
module ocp_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned RESP_LAT   = 2
) (
  input  logic                    Clk,
  input  logic                    MReset_n,
  input  logic [2:0]              MCmd,
  input  logic [ADDR_WIDTH-1:0]   MAddr,
  input  logic [DATA_WIDTH-1:0]   MData,
  input  logic [DATA_WIDTH/8-1:0] MByteEn,
  output logic                    SCmdAccept,
  output logic [1:0]              SResp,
  output logic [DATA_WIDTH-1:0]   SData,
  input  logic                    MRespAccept
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned OFF_W     = $clog2(BYTES);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam int unsigned MEM_BYTES = MEM_DEPTH * BYTES;
  localparam int unsigned CNT_W     = 4;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [1:0]            pend_code, pend_code_n;
  logic [1:0]            resp_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  is_wr;
  logic                  is_rd;
  logic                  supported;
  logic                  wants_resp;
  logic [DATA_WIDTH-1:0] rd_word;

  assign idx       = IDX_W'(MAddr >> OFF_W);
  assign in_range  = 64'(MAddr) < 64'(MEM_BYTES);
  assign is_wr     = (MCmd == CMD_WR);
  assign is_rd     = (MCmd == CMD_RD);
  assign supported = is_wr || is_rd;
  assign rd_word   = mem[idx];

`ifdef OCP_WRRESP_EN
  assign wants_resp = 1'b1;
`else
  // Posted writes never leave IDLE; reads and unsupported commands still respond.
  assign wants_resp = !is_wr;
`endif

  // Accept only in IDLE and never while reset is asserted.
  assign SCmdAccept = MReset_n && (state == ST_IDLE);

  // State register and registered response outputs.
  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend_code <= RESP_NULL;
      SResp     <= RESP_NULL;
      SData     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pend_code <= pend_code_n;
      SResp     <= resp_n;
      SData     <= data_n;
    end
  end

  // Next-state and response logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pend_code_n = pend_code;
    resp_n      = SResp;
    data_n      = SData;
    mem_we      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (MCmd != CMD_IDLE) begin
          mem_we = is_wr && in_range;
          if (wants_resp) begin
            pend_code_n = (supported && in_range) ? RESP_DVA : RESP_ERR;
            data_n      = (is_rd && in_range) ? rd_word : '0;
            if (RESP_LAT == 0) begin
              state_n = ST_RESP;
              resp_n  = pend_code_n;
            end else begin
              state_n = ST_WAIT;
              cnt_n   = CNT_W'(RESP_LAT - 1);
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_n = ST_RESP;
          resp_n  = pend_code;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (MRespAccept) begin
          state_n = ST_IDLE;
          resp_n  = RESP_NULL;
          data_n  = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Byte-enabled write, committed at the accept edge; contents survive reset.
  always_ff @(posedge Clk) begin
    if (mem_we && MReset_n) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (MByteEn[b]) begin
          mem[idx][8*b +: 8] <= MData[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Self-checking bench for ocp_slave_mem: directed plan items plus random traffic
// compared against a word-array reference model; follows OCP_WRRESP_EN like the DUT.
module tb_ocp_slave_mem;

  localparam int unsigned AW        = 16;
  localparam int unsigned DW        = 32;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned LAT       = 2;
  localparam int unsigned MEM_BYTES = DEPTH * 4;

`ifdef OCP_WRRESP_EN
  localparam bit WR_RESP = 1'b1;
`else
  localparam bit WR_RESP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          MReset_n;
  logic [2:0]    MCmd;
  logic [AW-1:0] MAddr;
  logic [DW-1:0] MData;
  logic [3:0]    MByteEn;
  logic          SCmdAccept;
  logic [1:0]    SResp;
  logic [DW-1:0] SData;
  logic          MRespAccept;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [DEPTH];
  bit          exp_resp;
  logic [1:0]  exp_code;
  logic [31:0] exp_data;

  ocp_slave_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .RESP_LAT   (LAT)
  ) dut (
    .Clk         (Clk),
    .MReset_n    (MReset_n),
    .MCmd        (MCmd),
    .MAddr       (MAddr),
    .MData       (MData),
    .MByteEn     (MByteEn),
    .SCmdAccept  (SCmdAccept),
    .SResp       (SResp),
    .SData       (SData),
    .MRespAccept (MRespAccept)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge, predict its outcome, and return at the next negedge.
  task automatic send(input logic [2:0] cmd, input logic [AW-1:0] addr,
                      input logic [31:0] data, input logic [3:0] be);
    int unsigned word;
    bit          in_r;
    MCmd    = cmd;
    MAddr   = addr;
    MData   = data;
    MByteEn = be;
    check("cmd_accept", 64'(SCmdAccept), 64'd1);
    in_r     = 32'(addr) < MEM_BYTES;
    word     = 32'(addr) / 4;
    exp_resp = (cmd != 3'd1) || WR_RESP;
    exp_code = ((cmd == 3'd1 || cmd == 3'd2) && in_r) ? 2'd1 : 2'd3;
    exp_data = (cmd == 3'd2 && in_r) ? mem_m[word] : 32'd0;
    if (cmd == 3'd1 && in_r) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[word][8*b +: 8] = data[8*b +: 8];
      end
    end
    @(negedge Clk);
    MCmd = 3'd0;
  endtask

  // Walk the latency window, hold the response for 'hold' cycles, then accept it.
  task automatic finish_resp(input int hold, input bit busy);
    if (!exp_resp) begin
      check("posted_sresp", 64'(SResp), 64'd0);
      check("posted_accept", 64'(SCmdAccept), 64'd1);
      return;
    end
    for (int k = 0; k < LAT; k++) begin
      check("wait_sresp", 64'(SResp), 64'd0);
      check("wait_accept", 64'(SCmdAccept), 64'd0);
      MRespAccept = 1'($urandom & 1);
      @(negedge Clk);
    end
    MRespAccept = 1'b0;
    check("resp_code", 64'(SResp), 64'(exp_code));
    check("resp_data", 64'(SData), 64'(exp_data));
    check("resp_accept", 64'(SCmdAccept), 64'd0);
    if (busy) begin
      MCmd  = 3'd2;
      MAddr = AW'(16'h0010);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      check("hold_code", 64'(SResp), 64'(exp_code));
      check("hold_data", 64'(SData), 64'(exp_data));
      check("hold_accept", 64'(SCmdAccept), 64'd0);
    end
    MRespAccept = 1'b1;
    @(negedge Clk);
    MRespAccept = 1'b0;
    MCmd        = 3'd0;
    check("done_sresp", 64'(SResp), 64'd0);
    check("done_sdata", 64'(SData), 64'd0);
    check("done_accept", 64'(SCmdAccept), 64'd1);
  endtask

  task automatic op(input logic [2:0] cmd, input logic [AW-1:0] addr,
                    input logic [31:0] data, input logic [3:0] be, input int hold);
    send(cmd, addr, data, be);
    finish_resp(hold, 1'b0);
  endtask

  initial begin
    logic [2:0]    rcmd;
    logic [AW-1:0] raddr;
    int unsigned   r;

    MReset_n    = 1'b0;
    MCmd        = 3'd0;
    MAddr       = '0;
    MData       = '0;
    MByteEn     = '0;
    MRespAccept = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_accept", 64'(SCmdAccept), 64'd0);
    check("rst_sresp", 64'(SResp), 64'd0);
    check("rst_sdata", 64'(SData), 64'd0);
    MReset_n = 1'b1;
    #1 check("rst_rel_accept", 64'(SCmdAccept), 64'd1);
    @(negedge Clk);

    // Basic write then read-back.
    op(3'd1, AW'(16'h0010), 32'hDEADBEEF, 4'hF, 0);
    op(3'd2, AW'(16'h0010), 32'h0, 4'h0, 0);

    // Partial write merge.
    op(3'd1, AW'(16'h0020), 32'h11223344, 4'hF, 0);
    op(3'd1, AW'(16'h0020), 32'hAABBCCDD, 4'h5, 0);
    op(3'd2, AW'(16'h0020), 32'h0, 4'h0, 1);

    // All-zero byte enables write nothing.
    op(3'd1, AW'(16'h0020), 32'h55667788, 4'h0, 0);
    op(3'd2, AW'(16'h0022), 32'h0, 4'h0, 0);

    // Backpressure with a competing read held on MCmd.
    send(3'd2, AW'(16'h0020), 32'h0, 4'h0);
    finish_resp(5, 1'b1);
    op(3'd2, AW'(16'h0010), 32'h0, 4'h0, 0);

    // Error cases: out-of-range read, unsupported command, out-of-range write.
    op(3'd1, AW'(16'h0000), 32'h0BADF00D, 4'hF, 0);
    op(3'd2, AW'(16'h1000), 32'h0, 4'h0, 0);
    op(3'd5, AW'(16'h0010), 32'hFFFFFFFF, 4'hF, 2);
    op(3'd2, AW'(16'h0010), 32'h0, 4'h0, 0);
    op(3'd1, AW'(16'h1000), 32'hCAFEBABE, 4'hF, 0);
    op(3'd2, AW'(16'h0000), 32'h0, 4'h0, 0);

    // Reset during WAIT of a read.
    send(3'd2, AW'(16'h0010), 32'h0, 4'h0);
    #2 MReset_n = 1'b0;
    #1 check("rstw_sresp", 64'(SResp), 64'd0);
    check("rstw_accept", 64'(SCmdAccept), 64'd0);
    @(negedge Clk);
    MReset_n = 1'b1;
    #1 check("rstw_rel_accept", 64'(SCmdAccept), 64'd1);
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge Clk);
      check("rstw_no_stale", 64'(SResp), 64'd0);
      check("rstw_idle_accept", 64'(SCmdAccept), 64'd1);
    end

    // Reset while a response is being presented.
    send(3'd2, AW'(16'h0020), 32'h0, 4'h0);
    repeat (LAT) @(negedge Clk);
    check("rstr_pre_code", 64'(SResp), 64'(exp_code));
    #2 MReset_n = 1'b0;
    #1 check("rstr_sresp", 64'(SResp), 64'd0);
    check("rstr_sdata", 64'(SData), 64'd0);
    @(negedge Clk);
    MReset_n = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      check("rstr_no_stale", 64'(SResp), 64'd0);
    end

    // A write committed before reset remains in memory.
    send(3'd1, AW'(16'h0030), 32'h13579BDF, 4'hF);
    #2 MReset_n = 1'b0;
    @(negedge Clk);
    MReset_n = 1'b1;
    @(negedge Clk);
    op(3'd2, AW'(16'h0030), 32'h0, 4'h0, 0);

    // Four consecutive writes, then read them back.
    for (int i = 0; i < 4; i++) begin
      send(3'd1, AW'(32'h0050 + 4 * i), 32'hA0A0_0000 + 32'(i * 32'h1111), 4'hF);
      finish_resp(0, 1'b0);
    end
    for (int i = 0; i < 4; i++) op(3'd2, AW'(32'h0050 + 4 * i), 32'h0, 4'h0, 0);

    // Random traffic over a small word pool plus out-of-range addresses.
    for (int i = 0; i < 8; i++) op(3'd1, AW'(32'h0400 + 4 * i), $urandom, 4'hF, 0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom % 10;
      if (r < 4)      rcmd = 3'd1;
      else if (r < 8) rcmd = 3'd2;
      else            rcmd = 3'(3 + $urandom % 5);
      if ($urandom % 6 == 0) raddr = AW'(32'h1000 + $urandom % 32'hE000);
      else                   raddr = AW'(32'h0400 + 4 * ($urandom % 8) + $urandom % 4);
      op(rcmd, raddr, $urandom, 4'($urandom), int'($urandom % 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
